// File: rtl/mux_pkg.sv
// Shared types and helpers for the round-robin output multiplexer.
package mux_pkg;

  // Largest channel count the search helper supports, and its index width.
  localparam int unsigned MAX_N = 64;
  localparam int unsigned IDX_W = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Width of a channel index for n channels.
  function automatic int unsigned sel_w(input int unsigned n);
    return $clog2(n);
  endfunction

  // First set bit of req searching from (ptr+1) mod n upward, wrapping once.
  function automatic pick_t rr_pick(input logic [MAX_N-1:0] req,
                                    input int unsigned     ptr,
                                    input int unsigned     n);
    pick_t       r;
    int unsigned idx;
    r = '0;
    for (int unsigned k = 1; k <= MAX_N; k++) begin
      idx = ptr + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !r.found && req[IDX_W'(idx)]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(idx);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational N-way round-robin pick; priority starts just after ptr.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned SW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_any
);

  logic [MAX_N-1:0] req_ext;
  pick_t            pick;

  // Widen the request vector and run the shared search.
  always_comb begin
    req_ext        = '0;
    req_ext[N-1:0] = req;
    pick           = rr_pick(req_ext, 32'(ptr), N);
    gnt_idx        = SW'(pick.idx);
    gnt_any        = pick.found;
  end

endmodule

// File: rtl/mux_rr_arb.sv
// N-channel registered multiplexer with round-robin arbitration and
// valid/ready handshakes. Optional MUX_RR_ARB_FORCE_EN adds force_en /
// force_sel to restrict the search to a single channel.
module mux_rr_arb
  import mux_pkg::*;
#(
  parameter  int unsigned N  = 8,
  parameter  int unsigned W  = 8,
  localparam int unsigned SW = sel_w(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [N-1:0]   in_valid,
  input  logic [N*W-1:0] in_data,
  output logic [N-1:0]   in_ready,
`ifdef MUX_RR_ARB_FORCE_EN
  input  logic           force_en,
  input  logic [SW-1:0]  force_sel,
`endif
  output logic           out_valid,
  output logic [W-1:0]   out_data,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  logic [SW-1:0] ptr;
  logic [N-1:0]  req_mask_c;
  logic [SW-1:0] gnt_idx_c;
  logic          gnt_any_c;
  logic          load_en_c;

  assign load_en_c = !out_valid || out_ready;

`ifdef MUX_RR_ARB_FORCE_EN
  // While forcing, only the selected channel may compete.
  always_comb begin
    req_mask_c = in_valid;
    if (force_en) begin
      req_mask_c = '0;
      if (32'(force_sel) < N) req_mask_c[force_sel] = in_valid[force_sel];
    end
  end
`else
  // Every valid channel competes.
  always_comb begin
    req_mask_c = in_valid;
  end
`endif

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arb (
    .req     (req_mask_c),
    .ptr     (ptr),
    .gnt_idx (gnt_idx_c),
    .gnt_any (gnt_any_c)
  );

  // Accept only the granted channel, and only when the output can load.
  always_comb begin
    in_ready = '0;
    if (load_en_c && gnt_any_c) in_ready[gnt_idx_c] = 1'b1;
  end

  // Output word, its source index and the priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= SW'(N - 1);
    end else if (load_en_c) begin
      if (gnt_any_c) begin
        out_valid <= 1'b1;
        out_data  <= in_data[32'(gnt_idx_c) * W +: W];
        out_sel   <= gnt_idx_c;
        ptr       <= gnt_idx_c;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mux_rr_arb.sv
// Directed self-checking bench for mux_rr_arb (N=8, W=8).
module tb_mux_rr_arb;

  localparam int unsigned N  = 8;
  localparam int unsigned W  = 8;
  localparam int unsigned SW = 3;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_ready;
`ifdef MUX_RR_ARB_FORCE_EN
  logic           force_en;
  logic [SW-1:0]  force_sel;
`endif

  int tests = 0;
  int fails = 0;

  mux_rr_arb #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
`ifdef MUX_RR_ARB_FORCE_EN
    .force_en  (force_en),
    .force_sel (force_sel),
`endif
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Channel i carries 0x10+i.
  task automatic load_pattern();
    for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = 8'(8'h10 + i);
  endtask

  task automatic check_out(input string tag, input logic [31:0] v,
                           input logic [31:0] d, input logic [31:0] s);
    check({tag, ".valid"}, 32'(out_valid), v);
    check({tag, ".data"},  32'(out_data),  d);
    check({tag, ".sel"},   32'(out_sel),   s);
  endtask

  initial begin
`ifdef MUX_RR_ARB_FORCE_EN
    force_en  = 1'b0;
    force_sel = '0;
`endif
    // Reset with random inputs.
    rst_n     = 1'b0;
    in_valid  = 8'($urandom);
    in_data   = 64'({$urandom, $urandom});
    out_ready = 1'($urandom);
    #12;
    check_out("reset", 0, 0, 0);
    in_valid = '0;
    #1;
    check("reset.in_ready", 32'(in_ready), 0);

    // Single channel 3.
    rst_n     = 1'b1;
    in_valid  = 8'b0000_1000;
    in_data   = '0;
    in_data[3*W +: W] = 8'hA5;
    out_ready = 1'b1;
    #1;
    check("single.in_ready", 32'(in_ready), 32'h08);
    tick();
    check_out("single", 1, 32'hA5, 3);

    // Fresh priority, then all channels valid: 0..7,0.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    load_pattern();
    in_valid = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      #1;
      check($sformatf("rr%0d.in_ready", k), 32'(in_ready), 32'(1) << (k % 8));
      tick();
      check_out($sformatf("rr%0d", k), 1, 32'h10 + (k % 8), k % 8);
    end

    // Backpressure: holding word 0 for three cycles.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.in_ready", k), 32'(in_ready), 0);
      tick();
      check_out($sformatf("bp%0d", k), 1, 32'h10, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_rel.in_ready", 32'(in_ready), 32'h02);
    tick();
    check_out("bp_rel", 1, 32'h11, 1);

    // Idle cycle: valid drops, data/sel hold.
    in_valid = '0;
    tick();
    check_out("idle", 0, 32'h11, 1);

    // Channels 0 and 2 from ptr=1: 2, then wrap to 0.
    in_valid = 8'b0000_0101;
    tick();
    check_out("wrap_a", 1, 32'h12, 2);
    tick();
    check_out("wrap_b", 1, 32'h10, 0);

    // Idle must not move ptr: from 0, channels 7 and 0 -> 7.
    in_valid = '0;
    tick();
    check("idle2.valid", 32'(out_valid), 0);
    in_valid = 8'b1000_0001;
    tick();
    check_out("hi", 1, 32'h17, 7);

`ifdef MUX_RR_ARB_FORCE_EN
    // Force channel 5 with everyone valid.
    force_en  = 1'b1;
    force_sel = 3'd5;
    in_valid  = 8'hFF;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("force%0d.in_ready", k), 32'(in_ready), 32'h20);
      tick();
      check_out($sformatf("force%0d", k), 1, 32'h15, 5);
    end
    in_valid = 8'hDF;
    #1;
    check("force_nv.in_ready", 32'(in_ready), 0);
    tick();
    check("force_nv.valid", 32'(out_valid), 0);
    force_en = 1'b0;
`endif

    // Mid-stream asynchronous reset.
    in_valid = 8'hFF;
    tick();
    check("mid.valid_pre", 32'(out_valid), 1);
    rst_n = 1'b0;
    #1;
    check("mid.valid_async", 32'(out_valid), 0);
    tick();
    rst_n = 1'b1;
    #1;
    check("mid.in_ready", 32'(in_ready), 32'h01);
    tick();
    check_out("mid_first", 1, 32'h10, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
